lfsr_seq_engine: RTL and testbench

Parametrised pseudo-random sequence engine. On `start` it generates a run of `length` values from an internal 16-bit LFSR, stores them in internal RAM and mirrors every write on an external write port. On `play` it replays the stored run over a valid/ready stream. It supersedes the fixed 32-entry, 4-bit generator and adds run length, seed load, playback and error reporting.

---
 rtl/lfsr_seq_if.sv | 32 +++
 rtl/lfsr_seq_engine.sv | 127 ++++++++++++
 tb/tb_lfsr_seq_engine.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_seq_if.sv
// Handshake bundle for lfsr_seq_engine: request/seed inputs, write mirror port
// and the playback valid/ready stream.
interface lfsr_seq_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 5
);
   logic              start;
   logic [ADDR_W:0]   length;
   logic              seed_load;
   logic [15:0]       seed;
   logic              play;
   logic              play_ready;
   logic              busy;
   logic              finish;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              play_valid;
   logic [DATA_W-1:0] play_data;
   logic              play_done;
   logic              err;

   modport master (
      output start, length, seed_load, seed, play, play_ready,
      input  busy, finish, wr_en, wr_addr, wr_data, play_valid, play_data, play_done, err
   );

   modport slave (
      input  start, length, seed_load, seed, play, play_ready,
      output busy, finish, wr_en, wr_addr, wr_data, play_valid, play_data, play_done, err
   );
endinterface

// File: rtl/lfsr_seq_engine.sv
// LFSR run generator: writes a run of LFSR samples into internal RAM (mirrored
// on an external write port) and replays the last completed run over valid/ready.
module lfsr_seq_engine #(
   parameter int          DATA_W    = 4,
   parameter int          ADDR_W    = 5,
   parameter logic [15:0] LFSR_SEED = 16'hBEEF
) (
   input logic       clk,
   input logic       rst,
   lfsr_seq_if.slave bus
);
   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GEN   = 3'd1;
   localparam logic [2:0] S_GDONE = 3'd2;
   localparam logic [2:0] S_PLAY  = 3'd3;
   localparam logic [2:0] S_PDONE = 3'd4;

   logic [2:0]        state;
   logic [15:0]       lfsr, lfsr_nxt;
   logic [ADDR_W:0]   run_len, stored_len;
   logic [ADDR_W-1:0] cnt, rd, rd_nxt, wr_idx;
   logic [DATA_W-1:0] ram [DEPTH];
   logic              len_ok, idle_start, last_wr, last_rd, gen_wr;

   assign lfsr_nxt   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign len_ok     = (bus.length != '0) && (bus.length <= DEPTH_L);
   assign idle_start = (state == S_IDLE) && !bus.seed_load && bus.start && len_ok;
   // Exit on the compare against the entry currently on the port, so a full
   // DEPTH run never wraps back onto entry 0.
   assign last_wr    = ({1'b0, bus.wr_addr} == run_len - 1'b1);
   assign last_rd    = ({1'b0, rd} == stored_len - 1'b1);
   assign gen_wr     = idle_start || ((state == S_GEN) && !last_wr);
   assign wr_idx     = idle_start ? '0 : cnt;
   assign rd_nxt     = rd + 1'b1;

   always_ff @(posedge clk) begin
      if (gen_wr) ram[wr_idx] <= lfsr[DATA_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         lfsr           <= LFSR_SEED;
         run_len        <= '0;
         stored_len     <= '0;
         cnt            <= '0;
         rd             <= '0;
         bus.busy       <= 1'b0;
         bus.finish     <= 1'b0;
         bus.wr_en      <= 1'b0;
         bus.wr_addr    <= '0;
         bus.wr_data    <= '0;
         bus.play_valid <= 1'b0;
         bus.play_data  <= '0;
         bus.play_done  <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         bus.finish    <= 1'b0;
         bus.play_done <= 1'b0;
         bus.err       <= 1'b0;
         bus.wr_en     <= gen_wr;
         // Outputs carry the pre-advance sample; the LFSR steps on the same edge.
         if (gen_wr) begin
            bus.wr_addr <= wr_idx;
            bus.wr_data <= lfsr[DATA_W-1:0];
            lfsr        <= lfsr_nxt;
            cnt         <= wr_idx + 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (bus.seed_load) begin
                  lfsr <= (bus.seed == 16'h0) ? LFSR_SEED : bus.seed;
               end else if (bus.start) begin
                  if (len_ok) begin
                     run_len  <= bus.length;
                     bus.busy <= 1'b1;
                     state    <= S_GEN;
                  end else begin
                     bus.err <= 1'b1;
                  end
               end else if (bus.play) begin
                  if (stored_len == '0) begin
                     bus.err <= 1'b1;
                  end else begin
                     rd             <= '0;
                     bus.play_data  <= ram['0];
                     bus.play_valid <= 1'b1;
                     bus.busy       <= 1'b1;
                     state          <= S_PLAY;
                  end
               end
            end
            S_GEN: begin
               if (last_wr) begin
                  bus.finish <= 1'b1;
                  state      <= S_GDONE;
               end
            end
            S_GDONE: begin
               stored_len <= run_len;
               bus.busy   <= 1'b0;
               state      <= S_IDLE;
            end
            S_PLAY: begin
               if (bus.play_ready) begin
                  if (last_rd) begin
                     bus.play_valid <= 1'b0;
                     bus.play_done  <= 1'b1;
                     state          <= S_PDONE;
                  end else begin
                     rd            <= rd_nxt;
                     bus.play_data <= ram[rd_nxt];
                  end
               end
            end
            S_PDONE: begin
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lfsr_seq_engine.sv
// Self-checking bench for lfsr_seq_engine: directed table, hand-written corner
// sequences and randomized requests against a queue-based reference model.
module tb_lfsr_seq_engine;
   localparam int DW = 4;
   localparam int AW = 5;
   localparam int DEPTH = 32;
   localparam int K_START = 0, K_PLAY = 1, K_SEED = 2;

   typedef struct {
      int kind;
      int val;       // length for start, ready mode for play, seed for seed_load
      int exp_err;
      int exp_first; // -1: no constant expectation on the first written value
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lfsr_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
   lfsr_seq_engine #(.DATA_W(DW), .ADDR_W(AW), .LFSR_SEED(16'hBEEF)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   logic [15:0]   m_lfsr;
   logic [DW-1:0] m_store[$];
   logic [DW-1:0] got_wr[$];
   vec_t          tbl[10];

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      // shift left, feed back parity of taps 15,13,12,10
      return 16'((32'(s) << 1) | 32'(^(s & 16'hB400)));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_seed(input int s);
      bus.seed_load = 1'b1;
      bus.seed      = 16'(s);
      @(negedge clk);
      bus.seed_load = 1'b0;
      chk("seed_busy", 32'(bus.busy), 0);
      chk("seed_err", 32'(bus.err), 0);
      m_lfsr = (s == 0) ? 16'hBEEF : 16'(s);
   endtask

   task automatic do_start(input int len, input int exp_err, input bit also_play);
      logic [DW-1:0] exp_vals[$];
      logic [DW-1:0] e;
      got_wr.delete();
      bus.start  = 1'b1;
      bus.length = 6'(len);
      bus.play   = also_play;
      @(negedge clk);
      bus.start = 1'b0;
      bus.play  = 1'b0;
      if (exp_err != 0) begin
         chk("start_err", 32'(bus.err), 1);
         chk("start_err_no_wr", 32'(bus.wr_en), 0);
         chk("start_err_busy", 32'(bus.busy), 0);
         @(negedge clk);
         chk("start_err_pulse", 32'(bus.err), 0);
         return;
      end
      for (int i = 0; i < len; i++) begin
         e = m_lfsr[DW-1:0];
         chk("wr_en", 32'(bus.wr_en), 1);
         chk("wr_addr", 32'(bus.wr_addr), 32'(i));
         chk("wr_data", 32'(bus.wr_data), 32'(e));
         chk("gen_busy", 32'(bus.busy), 1);
         chk("gen_finish", 32'(bus.finish), 0);
         if (also_play) chk("gen_no_play", 32'(bus.play_valid), 0);
         got_wr.push_back(bus.wr_data);
         exp_vals.push_back(e);
         m_lfsr = lfsr_step(m_lfsr);
         @(negedge clk);
      end
      chk("finish", 32'(bus.finish), 1);
      chk("finish_wr_en", 32'(bus.wr_en), 0);
      chk("finish_busy", 32'(bus.busy), 1);
      m_store = exp_vals;
      @(negedge clk);
      chk("finish_pulse", 32'(bus.finish), 0);
      chk("gen_idle_busy", 32'(bus.busy), 0);
   endtask

   task automatic do_play(input int mode, input int exp_err);
      bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int idx = 0;
      int cyc = 0;
      int len;
      bit r;
      bus.play = 1'b1;
      @(negedge clk);
      bus.play = 1'b0;
      if (exp_err != 0) begin
         chk("play_err", 32'(bus.err), 1);
         chk("play_err_valid", 32'(bus.play_valid), 0);
         @(negedge clk);
         chk("play_err_pulse", 32'(bus.err), 0);
         return;
      end
      len = m_store.size();
      while (idx < len && cyc < 8 * len + 20) begin
         chk("play_valid", 32'(bus.play_valid), 1);
         chk("play_data", 32'(bus.play_data), 32'(m_store[idx]));
         chk("play_no_done", 32'(bus.play_done), 0);
         r = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'(($urandom_range(0, 1)));
         bus.play_ready = r;
         if (r) idx++;
         cyc++;
         @(negedge clk);
      end
      bus.play_ready = 1'b0;
      if (idx < len) chk("play_timeout", 32'(idx), 32'(len));
      chk("play_done", 32'(bus.play_done), 1);
      chk("play_end_valid", 32'(bus.play_valid), 0);
      @(negedge clk);
      chk("play_done_pulse", 32'(bus.play_done), 0);
      chk("play_idle_busy", 32'(bus.busy), 0);
   endtask

   initial begin
      tbl[0] = '{K_START, 0,  1, -1};
      tbl[1] = '{K_START, 33, 1, -1};
      tbl[2] = '{K_START, 32, 0, -1};
      tbl[3] = '{K_PLAY,  0,  0, -1};
      tbl[4] = '{K_PLAY,  1,  0, -1};
      tbl[5] = '{K_SEED,  0,  0, -1};
      tbl[6] = '{K_START, 1,  0, 15};
      tbl[7] = '{K_SEED,  1,  0, -1};
      tbl[8] = '{K_START, 1,  0, 1};
      tbl[9] = '{K_PLAY,  1,  0, -1};

      bus.start = 0; bus.length = '0; bus.seed_load = 0; bus.seed = '0;
      bus.play = 0; bus.play_ready = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_lfsr = 16'hBEEF;
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_finish", 32'(bus.finish), 0);
      chk("rst_wr_en", 32'(bus.wr_en), 0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 0);
      chk("rst_wr_data", 32'(bus.wr_data), 0);
      chk("rst_play_valid", 32'(bus.play_valid), 0);
      chk("rst_play_data", 32'(bus.play_data), 0);
      chk("rst_play_done", 32'(bus.play_done), 0);
      chk("rst_err", 32'(bus.err), 0);

      do_play(0, 1);
      do_start(3, 0, 1'b0);
      if (got_wr.size() == 3) begin
         chk("first_wr0", 32'(got_wr[0]), 32'hF);
         chk("first_wr1", 32'(got_wr[1]), 32'hE);
         chk("first_wr2", 32'(got_wr[2]), 32'hD);
      end else chk("first_wr_count", 32'(got_wr.size()), 3);

      for (int i = 0; i < 10; i++) begin
         case (tbl[i].kind)
            K_START: begin
               do_start(tbl[i].val, tbl[i].exp_err, 1'b0);
               if (tbl[i].exp_first >= 0) begin
                  if (got_wr.size() > 0) chk("tbl_first", 32'(got_wr[0]), 32'(tbl[i].exp_first));
                  else chk("tbl_first_missing", 0, 1);
               end
            end
            K_PLAY:  do_play(tbl[i].val, tbl[i].exp_err);
            default: do_seed(tbl[i].val);
         endcase
      end

      // start and play together: start wins, play is dropped
      do_start(2, 0, 1'b1);
      chk("start_wins_no_play", 32'(bus.play_valid), 0);

      // reset in the middle of a 20-entry run, on its 5th write
      bus.start = 1'b1; bus.length = 6'd20;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_wr_addr", 32'(bus.wr_addr), 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_outs", 32'({bus.busy, bus.finish, bus.wr_en, bus.wr_addr, bus.wr_data,
                              bus.play_valid, bus.play_data, bus.play_done, bus.err}), 0);
      m_lfsr = 16'hBEEF;
      m_store.delete();
      do_play(0, 1);
      do_start(1, 0, 1'b0);
      if (got_wr.size() == 1) chk("abort_restart", 32'(got_wr[0]), 32'hF);
      else chk("abort_restart_count", 32'(got_wr.size()), 1);

      for (int n = 0; n < 30; n++) begin
         int sel, len;
         sel = int'($urandom_range(0, 9));
         if (sel < 5) begin
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) * 33
                                             : int'($urandom_range(1, DEPTH));
            do_start(len, (len < 1 || len > DEPTH) ? 1 : 0, 1'b0);
         end else if (sel < 8) begin
            do_play(2, (m_store.size() == 0) ? 1 : 0);
         end else begin
            do_seed(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 65535)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
